// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_add_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/koggestone_add4.sv
// 4-bit Kogge-Stone parallel-prefix adder with carry-in; purely combinational.
module koggestone_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g0;
  logic [3:0] p0;
  logic [3:0] g1;
  logic [3:2] p1;
  logic [3:0] g2;

  // Carry-in is folded into bit 0 so the prefix tree yields carries directly.
  always_comb begin
    p     = a ^ b;
    p0    = p;
    g0    = a & b;
    g0[0] = g0[0] | (p[0] & cin);
    g1    = g0;
    p1    = p0[3:2] & p0[2:1];
    for (int i = 1; i < 4; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
    end
    g2 = g1;
    for (int i = 2; i < 4; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
    end
    sum  = p ^ {g2[2:0], cin};
    cout = g2[3];
  end

endmodule

// File: rtl/nibble_add_seq.sv
// Multi-cycle adder: processes one 4-bit slice per enabled clock through a
// single shared Kogge-Stone adder, LSB slice first.
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       start,
  input  logic [SLICE_W*NIBBLES-1:0] a,
  input  logic [SLICE_W*NIBBLES-1:0] b,
  input  logic                       cin,
  output logic                       busy,
  output logic                       done,
  output logic [SLICE_W*NIBBLES-1:0] sum,
  output logic                       cout
);

  localparam int unsigned W     = SLICE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  int unsigned        base_c;
  logic [SLICE_W-1:0] add_sum_c;
  logic               add_cout_c;
  logic               last_c;

  assign base_c = SLICE_W * 32'(idx_q);
  assign last_c = (idx_q == IDX_W'(NIBBLES - 1));

  koggestone_add4 u_add (
    .a    (a_q[base_c +: SLICE_W]),
    .b    (b_q[base_c +: SLICE_W]),
    .cin  (carry_q),
    .sum  (add_sum_c),
    .cout (add_cout_c)
  );

  // Next-state and datapath updates; everything holds while ena is low.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (ena) begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            sum_d   = '0;
            idx_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          sum_d[base_c +: SLICE_W] = add_sum_c;
          carry_d                  = add_cout_c;
          if (last_c) begin
            cout_d  = add_cout_c;
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit slices per operand, so operand width W = 4*NIBBLES.
REQ-002 SHALL have input clk, 1 bit: sole clock; all state updates on rising edge.
REQ-003 SHALL have input rst_n, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have input ena, 1 bit: global enable; low freezes all state.
REQ-005 SHALL have input start, 1 bit: request a new addition; sampled only when accepted (REQ-013).
REQ-006 SHALL have input a, W bits: operand A, captured on start acceptance.
REQ-007 SHALL have input b, W bits: operand B, captured on start acceptance.
REQ-008 SHALL have input cin, 1 bit: carry-in, captured on start acceptance.
REQ-009 SHALL have output busy, 1 bit: high while an addition is in progress.
REQ-010 SHALL have output done, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have output sum, W bits: result register.
REQ-012 SHALL have output cout, 1 bit: final carry-out register.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE; start is accepted only in IDLE or DONE with ena=1.
REQ-014 On acceptance SHALL latch a, b and cin, clear sum to 0, set slice index idx=0, and enter RUN.
REQ-015 In RUN with ena=1, each edge SHALL add slice idx of A and B plus carry via one shared 4-bit Kogge-Stone adder, write the 4-bit result into sum[4*idx+3:4*idx], load the adder carry-out into the carry register, and increment idx.
REQ-016 When the slice at idx=NIBBLES-1 is processed, the FSM SHALL enter DONE and load cout from the final carry.
REQ-017 done SHALL equal (state==DONE) and be high for exactly one cycle when ena=1; DONE SHALL go to IDLE (no start) or to RUN (start accepted).
REQ-018 busy SHALL equal (state==RUN).
REQ-019 Latency: with ena held high, done SHALL be high in the cycle after edge k+NIBBLES, where edge k is the start-accept edge, i.e. NIBBLES+1 edges after acceptance.
REQ-020 start while in RUN SHALL be ignored; operands latched earlier SHALL be unaffected by changes on a/b/cin.
REQ-021 With ena=0, state, idx, carry, sum, cout and done SHALL hold; the done pulse extends until the first ena=1 edge.
REQ-022 sum and cout SHALL hold the last result in IDLE until the next acceptance.
REQ-023 Arithmetic SHALL be modulo 2^W, with overflow reported only in cout; idx SHALL never exceed NIBBLES-1.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, idx=0, carry=0, operand registers=0, sum=0, cout=0, busy=0 and done=0, including mid-RUN.
REQ-025 After rst_n deasserts, the first start acceptance SHALL behave exactly as from power-up.

Structure
REQ-026 Package nibble_add_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and constant SLICE_W=4.
REQ-027 The 4-bit Kogge-Stone adder SHALL be a separate combinational sub-module koggestone_add4 (a, b, cin -> sum[3:0], cout), instantiated once.
REQ-028 The idx counter width SHALL be $clog2(NIBBLES), minimum 1.

Verification
REQ-029 a=0x1234, b=0x4321, cin=0, ena=1 -> sum=0x5555, cout=0, done high 5 edges after accept.
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all 4 slices); also a=0, b=0, cin=1 -> sum=0x0001, cout=0.
REQ-031 a=0x8000, b=0x8000, with ena low 3 cycles during RUN -> sum=0x0000, cout=1, done 3 cycles later than REQ-019, busy held throughout.
REQ-032 start with a=0x0F0F, b=0x0101 asserted again mid-RUN with different operands -> second start ignored, sum=0x1010.
REQ-033 rst_n pulsed low during RUN idx=2 -> all outputs 0 at once; a new start with a=0x0001, b=0x0002 -> sum=0x0003, cout=0.
REQ-034 start held high across DONE -> back-to-back accept, done pulses exactly 5 cycles apart, both results correct.
